// File: rtl/alu_bist.sv
// Built-in self-test engine for the Alu_riscv datapath: walks 14 opcodes x NUM_VECTORS
// operand vectors through the ALU and compares result/flag against an internal golden model.
module alu_bist #(
  parameter int          NUM_VECTORS   = 8,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_op_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_flag_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [7:0]  err_count_o,
  output logic [4:0]  fail_op_o,
  output logic [7:0]  fail_vec_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [4:0]  LAST_OP   = 5'd13;
  localparam logic [7:0]  LAST_IDX  = 8'(NUM_VECTORS - 1);
  localparam int          CW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

  state_t        state_q;
  logic [31:0]   lfsr_q;
  logic [7:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   alu_a_q;
  logic [31:0]   alu_b_q;
  logic [4:0]    alu_op_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [7:0]    err_q;
  logic [4:0]    fail_op_q;
  logic [7:0]    fail_vec_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] vec_a(input logic [7:0] idx, input logic [31:0] lfsr);
    case (idx)
      8'd0:    return 32'h0000_0000;
      8'd1:    return 32'hFFFF_FFFF;
      8'd2:    return 32'h8000_0000;
      default: return lfsr;
    endcase
  endfunction

  function automatic logic [31:0] vec_b(input logic [7:0] idx, input logic [31:0] lfsr);
    case (idx)
      8'd0:    return 32'h0000_0000;
      8'd1:    return 32'h0000_0001;
      8'd2:    return 32'h7FFF_FFFF;
      8'd3:    return lfsr;
      default: return lfsr_step(lfsr);
    endcase
  endfunction

  // Returns {flag, result}; comparison ops mirror the flag into result[0].
  function automatic logic [32:0] golden(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    logic [4:0]  sh;
    r  = 32'h0;
    f  = 1'b0;
    sh = b[4:0];
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a ^ b;
      5'd3:  r = a | b;
      5'd4:  r = a & b;
      5'd5:  r = $signed(a) >>> sh;
      5'd6:  r = a >> sh;
      5'd7:  r = a << sh;
      5'd8:  f = $signed(a) < $signed(b);
      5'd9:  f = a < b;
      5'd10: f = $signed(a) >= $signed(b);
      5'd11: f = a >= b;
      5'd12: f = a == b;
      5'd13: f = a != b;
      default: f = 1'b0;
    endcase
    if (op >= 5'd8) r = {31'b0, f};
    return {f, r};
  endfunction

  logic [32:0] exp_d;
  logic        mismatch_d;
  logic [31:0] lfsr_d;
  logic [7:0]  idx_d;
  logic [4:0]  op_d;
  logic        last_idx_d;

  always_comb begin
    exp_d      = golden(alu_op_q, alu_a_q, alu_b_q);
    mismatch_d = (alu_result_i != exp_d[31:0]) || (alu_flag_i != exp_d[32]);
    lfsr_d     = (idx_q >= 8'd3) ? lfsr_step(lfsr_step(lfsr_q)) : lfsr_q;
    last_idx_d = (idx_q == LAST_IDX);
    idx_d      = last_idx_d ? 8'd0 : idx_q + 8'd1;
    op_d       = last_idx_d ? alu_op_q + 5'd1 : alu_op_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      idx_q      <= 8'd0;
      cnt_q      <= '0;
      alu_a_q    <= 32'h0;
      alu_b_q    <= 32'h0;
      alu_op_q   <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 8'd0;
      fail_op_q  <= 5'd0;
      fail_vec_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lfsr_q     <= LFSR_SEED;
            idx_q      <= 8'd0;
            cnt_q      <= '0;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_op_q   <= 5'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 8'd0;
            fail_op_q  <= 5'd0;
            fail_vec_q <= 8'd0;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q == LAST_CNT) state_q <= S_CHECK;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        S_CHECK: begin
          if (mismatch_d) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            // Zero errors so far means this is the first mismatch of the run.
            if (err_q == 8'd0) begin
              fail_op_q  <= alu_op_q;
              fail_vec_q <= idx_q;
            end
          end
          lfsr_q <= lfsr_d;
          cnt_q  <= '0;
          if (last_idx_d && alu_op_q == LAST_OP) begin
            state_q <= S_DONE;
          end else begin
            idx_q    <= idx_d;
            alu_op_q <= op_d;
            alu_a_q  <= vec_a(idx_d, lfsr_d);
            alu_b_q  <= vec_b(idx_d, lfsr_d);
            state_q  <= S_DRIVE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_q == 8'd0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_op_o   = fail_op_q;
  assign fail_vec_o  = fail_vec_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU with selectable faults feeds the engine, and a
// vector-list reference model predicts the operand stream, error count and first failure.
module tb_alu_bist;

  localparam int          NV    = 8;
  localparam int          NV_W  = 40;
  localparam int          SC    = 1;
  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_i, start_w;
  logic [31:0] alu_a, alu_b, alu_res, alu_a_w, alu_b_w, alu_res_w;
  logic [4:0]  alu_op, alu_op_w, fop, fop_w;
  logic        alu_flag, alu_flag_w, busy, busy_w, done, done_w, pass, pass_w;
  logic [7:0]  err, err_w, fvec, fvec_w;

  int          fault_mode;
  logic [4:0]  fault_op;
  logic [13:0] op_mask;
  logic [31:0] salt;
  int          fbit;
  bit          mon_en;

  int total = 0;
  int bad   = 0;

  logic [68:0] exp_q[$];
  logic [68:0] samp_q[$];

  alu_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_res), .alu_flag_i(alu_flag),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err),
    .fail_op_o(fop), .fail_vec_o(fvec)
  );

  alu_bist #(.NUM_VECTORS(NV_W), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) u_dut_w (
    .clk(clk), .rst(rst), .start_i(start_w),
    .alu_a_o(alu_a_w), .alu_b_o(alu_b_w), .alu_op_o(alu_op_w),
    .alu_result_i(alu_res_w), .alu_flag_i(alu_flag_w),
    .busy_o(busy_w), .done_o(done_w), .pass_o(pass_w), .err_count_o(err_w),
    .fail_op_o(fop_w), .fail_vec_o(fvec_w)
  );

  function automatic logic [31:0] next_lfsr(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Reference ALU, {flag, result}; signed ops via 64-bit arithmetic.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    longint      sa, sb;
    r  = 32'h0;
    f  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a ^ b;
      5'd3:  r = a | b;
      5'd4:  r = a & b;
      5'd5:  r = 32'(sa >>> b[4:0]);
      5'd6:  r = a >> b[4:0];
      5'd7:  r = a << b[4:0];
      5'd8:  f = sa < sb;
      5'd9:  f = a < b;
      5'd10: f = sa >= sb;
      5'd11: f = a >= b;
      5'd12: f = a == b;
      5'd13: f = a != b;
      default: f = 1'b0;
    endcase
    if (op >= 5'd8) r = {31'b0, f};
    return {f, r};
  endfunction

  function automatic logic [32:0] bad_alu(input int mode, input logic [4:0] fo,
                                          input logic [13:0] mask, input logic [31:0] slt,
                                          input int bi, input logic [4:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [32:0] v;
    v = ref_alu(op, a, b);
    case (mode)
      1: if (op == fo) v[0] = ~v[0];
      2: if (op == fo) v[32] = 1'b0;
      3: v[31:0] = 32'h0;
      4: if (op < 5'd14 && mask[op[3:0]] && ((a ^ b ^ slt) & 32'h3) == 32'h0)
           v[bi[4:0]] = ~v[bi[4:0]];
      default: ;
    endcase
    return v;
  endfunction

  always_comb {alu_flag, alu_res} =
    bad_alu(fault_mode, fault_op, op_mask, salt, fbit, alu_op, alu_a, alu_b);
  always_comb {alu_flag_w, alu_res_w} =
    bad_alu(fault_mode, fault_op, op_mask, salt, fbit, alu_op_w, alu_a_w, alu_b_w);

  always @(negedge clk) if (mon_en && busy) samp_q.push_back({alu_op, alu_a, alu_b});

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Walks the full vector list; expected error count clamped at 255.
  task automatic run_model(input int nv, input bit fill, output logic [7:0] e_err,
                           output logic [4:0] e_op, output logic [7:0] e_vec);
    logic [31:0] lfsr, a, b;
    logic [4:0]  o;
    int          n;
    bit          found;
    lfsr  = SEED;
    n     = 0;
    found = 0;
    e_op  = 5'd0;
    e_vec = 8'd0;
    if (fill) exp_q.delete();
    for (int op = 0; op < 14; op++) begin
      o = 5'(op);
      for (int idx = 0; idx < nv; idx++) begin
        if (idx == 0)      begin a = 32'h0;         b = 32'h0;         end
        else if (idx == 1) begin a = 32'hFFFF_FFFF; b = 32'h1;         end
        else if (idx == 2) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
        else begin
          a = lfsr;
          b = (idx == 3) ? lfsr : next_lfsr(lfsr);
          lfsr = next_lfsr(next_lfsr(lfsr));
        end
        if (fill) exp_q.push_back({o, a, b});
        if (ref_alu(o, a, b) != bad_alu(fault_mode, fault_op, op_mask, salt, fbit, o, a, b)) begin
          if (!found) begin
            e_op  = o;
            e_vec = 8'(idx);
            found = 1;
          end
          n++;
        end
      end
    end
    e_err = (n > 255) ? 8'hFF : 8'(n);
  endtask

  // driver: one full run of the default instance, optional extra start pulses mid-run
  task automatic run_main(input string nm, input int p1, input int p2);
    logic [7:0]  e_err, e_vec;
    logic [4:0]  e_op;
    logic [68:0] rv[$];
    int          rl[$];
    int          lat, nhold, nrun;
    run_model(NV, 1, e_err, e_op, e_vec);
    samp_q.delete();
    mon_en = 1;
    @(negedge clk) start_i = 1'b1;
    @(posedge clk) #1;
    check({nm, "_busy_rise"}, 69'(busy), 69'd1);
    check({nm, "_done_clr"}, 69'(done), 69'd0);
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clk) start_i = ((lat + 1) == p1) || ((lat + 1) == p2);
      @(posedge clk) #1;
      lat++;
    end
    start_i = 1'b0;
    mon_en  = 0;
    check({nm, "_done_lat"}, 69'(lat), 69'(14 * NV * (SC + 1) + 1));
    check({nm, "_busy_fall"}, 69'(busy), 69'd0);
    check({nm, "_pass"}, 69'(pass), 69'(e_err == 8'd0));
    check({nm, "_err"}, 69'(err), 69'(e_err));
    check({nm, "_fail_op"}, 69'(fop), 69'(e_op));
    check({nm, "_fail_vec"}, 69'(fvec), 69'(e_vec));
    foreach (samp_q[i]) begin
      if (i == 0 || samp_q[i] != samp_q[i-1]) begin
        rv.push_back(samp_q[i]);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    check({nm, "_vec_count"}, 69'(rv.size()), 69'(exp_q.size()));
    nrun  = (rv.size() < exp_q.size()) ? rv.size() : exp_q.size();
    nhold = 0;
    for (int i = 0; i < nrun; i++) begin
      check($sformatf("%s_vec%0d", nm, i), rv[i], exp_q[i]);
      if (i < nrun - 1 && rl[i] != SC + 1) nhold++;
    end
    check({nm, "_vec_hold"}, 69'(nhold), 69'd0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_busy"}, 69'(busy), 69'd0);
    check({nm, "_done"}, 69'(done), 69'd0);
    check({nm, "_pass"}, 69'(pass), 69'd0);
    check({nm, "_err"}, 69'(err), 69'd0);
    check({nm, "_fail_op"}, 69'(fop), 69'd0);
    check({nm, "_fail_vec"}, 69'(fvec), 69'd0);
    check({nm, "_alu"}, {alu_op, alu_a, alu_b}, 69'd0);
  endtask

  initial begin
    logic [7:0] e_err, e_vec;
    logic [4:0] e_op;
    int         lat, seen;
    rst        = 1'b1;
    start_i    = 1'b0;
    start_w    = 1'b0;
    mon_en     = 0;
    fault_mode = 0;
    fault_op   = 5'd0;
    op_mask    = 14'd0;
    salt       = 32'd0;
    fbit       = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("rst");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    run_main("clean", 0, 0);
    repeat (5) @(posedge clk);
    #1 check("done_hold", 69'({done, pass}), 69'b11);

    fault_mode = 1; fault_op = 5'd2;
    run_main("xor_flip", 0, 0);
    fault_mode = 2; fault_op = 5'd13;
    run_main("ne_flag0", 0, 0);
    fault_mode = 2; fault_op = 5'($urandom_range(8, 12));
    run_main("cmp_flag0", 0, 0);

    for (int it = 0; it < 4; it++) begin
      fault_mode = 4;
      op_mask    = 14'($urandom_range(1, 16383));
      salt       = $urandom;
      fbit       = $urandom_range(0, 32);
      run_main($sformatf("rnd%0d", it), 0, 0);
    end

    // abort: reset 50 cycles into a failing run
    fault_mode = 1; fault_op = 5'd2;
    @(negedge clk) start_i = 1'b1;
    @(posedge clk) #1 start_i = 1'b0;
    repeat (49) @(posedge clk);
    #1 check("pre_abort_busy", 69'(busy), 69'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 check_reset_state("abort");
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (300) begin
      @(posedge clk) #1;
      if (done || busy) seen++;
    end
    check("abort_quiet", 69'(seen), 69'd0);
    fault_mode = 0;
    run_main("restart", 0, 0);

    run_main("ignore_start", 10, 100);
    seen = 0;
    repeat (30) begin
      @(posedge clk) #1;
      if (busy) seen++;
    end
    check("single_run", 69'(seen), 69'd0);

    // start and reset on the same edge
    @(negedge clk) begin rst = 1'b1; start_i = 1'b1; end
    @(posedge clk) #1 check("rst_wins_busy", 69'(busy), 69'd0);
    @(negedge clk) begin rst = 1'b0; start_i = 1'b0; end
    @(posedge clk) #1 check("rst_wins_idle", 69'(busy), 69'd0);

    // saturation on the wide instance
    fault_mode = 3;
    run_model(NV_W, 0, e_err, e_op, e_vec);
    @(negedge clk) start_w = 1'b1;
    @(posedge clk) #1 start_w = 1'b0;
    lat = 0;
    while (!done_w && lat < 5000) begin
      @(posedge clk) #1;
      lat++;
    end
    check("sat_lat", 69'(lat), 69'(14 * NV_W * (SC + 1) + 1));
    check("sat_err", 69'(err_w), 69'(e_err));
    check("sat_err_max", 69'(err_w), 69'hFF);
    check("sat_fail_op", 69'(fop_w), 69'(e_op));
    check("sat_fail_vec", 69'(fvec_w), 69'(e_vec));
    check("sat_pass", 69'(pass_w), 69'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
